// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS run controller.
// The optional watchdog is enabled with RUN_CTRL_WDOG_EN.
package mips_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 6;
    localparam logic [31:0] CYC_MAX    = 32'hFFFF_FFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD    = 3'd1;
    localparam state_t ST_RUN     = 3'd2;
    localparam state_t ST_STEP    = 3'd3;
    localparam state_t ST_BREAK   = 3'd4;
    localparam state_t ST_TIMEOUT = 3'd5;

endpackage

// File: rtl/mips_imem_loader.sv
// Instruction-memory load port: valid/ready intake, word address
// counter and a registered one-word-per-cycle write port.
module mips_imem_loader
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              en_i,
    input  logic              valid_i,
    input  logic [31:0]       data_i,
    output logic              ready_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    logic [ADDR_W-1:0] acc_q, acc_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hs;

    // Once the last address is accepted, intake stops: no wrap.
    assign ready_o = en_i && !full_q;
    assign hs      = ready_o && valid_i;

    always_comb begin
        acc_d   = acc_q;
        full_d  = full_q;
        we_d    = hs;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (start_i) begin
            acc_d   = '0;
            full_d  = 1'b0;
            waddr_d = '0;
        end else if (hs) begin
            waddr_d = acc_q;
            wdata_d = data_i;
            acc_d   = acc_q + 1'b1;
            full_d  = (acc_q == LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            acc_q   <= '0;
            full_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            acc_q   <= acc_d;
            full_q  <= full_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign we_o    = we_q;
    assign addr_o  = waddr_q;
    assign wdata_o = wdata_q;
    assign done_o  = we_q && (waddr_q == LAST);

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/step/pause/breakpoint controller for the single-cycle MIPS core.
// Define RUN_CTRL_WDOG_EN to add the run-length watchdog (TIMEOUT).
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              BTN_RUN,
    input  logic              BTN_STEP,
    input  logic              BTN_LOAD,
    input  logic              LD_VALID,
    input  logic [31:0]       LD_DATA,
    output logic              LD_READY,
    output logic              IM_WE,
    output logic [ADDR_W-1:0] IM_ADDR,
    output logic [31:0]       IM_WDATA,
    output logic              CPU_EN,
    output logic              CPU_RST_N,
    input  logic [31:0]       PC,
    input  logic              BRK_EN,
    input  logic [31:0]       BRK_PC,
    output logic [2:0]        STATE,
    output logic [31:0]       CYCLES
);

    state_t      state_q, state_d;
    logic [31:0] cycles_q, cycles_d;
    logic        skip_q, skip_d;
    logic        crst_q;
    logic        hit, cpu_en, wdog_trip;
    logic        ld_start, ld_en, ld_done, ld_exit;

    assign hit    = BRK_EN && (PC == BRK_PC) && !skip_q;
    assign cpu_en = (state_q == ST_STEP) ||
                    ((state_q == ST_RUN) && !hit);

    assign ld_en    = (state_q == ST_LOAD) && !BTN_LOAD;
    assign ld_start = (state_d == ST_LOAD) && (state_q != ST_LOAD);
    assign ld_exit  = (state_q == ST_LOAD) && (state_d == ST_IDLE);

    mips_imem_loader #(
        .ADDR_W (ADDR_W)
    ) u_loader (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .start_i (ld_start),
        .en_i    (ld_en),
        .valid_i (LD_VALID),
        .data_i  (LD_DATA),
        .ready_o (LD_READY),
        .we_o    (IM_WE),
        .addr_o  (IM_ADDR),
        .wdata_o (IM_WDATA),
        .done_o  (ld_done)
    );

`ifdef RUN_CTRL_WDOG_EN
    logic [31:0] wcnt_q, wcnt_d;

    assign wdog_trip = cpu_en &&
                       ((wcnt_q + 32'd1) == 32'(WDOG_CYCLES));

    always_comb begin
        wcnt_d = wcnt_q;
        if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
            wcnt_d = '0;
        end else if ((state_q == ST_RUN) && cpu_en) begin
            wcnt_d = wcnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) wcnt_q <= '0;
        else      wcnt_q <= wcnt_d;
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^32'(WDOG_CYCLES);
    assign wdog_trip   = 1'b0;
`endif

    // Button priority is LOAD > RUN > STEP; invalid pulses fall through.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_BREAK: begin
                if (BTN_LOAD)      state_d = ST_LOAD;
                else if (BTN_RUN)  state_d = ST_RUN;
                else if (BTN_STEP) state_d = ST_STEP;
            end
            ST_LOAD: begin
                if (BTN_LOAD || ld_done) state_d = ST_IDLE;
            end
            ST_RUN: begin
                if (BTN_LOAD)       state_d = ST_LOAD;
                else if (BTN_RUN)   state_d = ST_IDLE;
                else if (hit)       state_d = ST_BREAK;
                else if (wdog_trip) state_d = ST_TIMEOUT;
            end
            ST_STEP: state_d = ST_IDLE;
`ifdef RUN_CTRL_WDOG_EN
            ST_TIMEOUT: begin
                if (BTN_LOAD) state_d = ST_LOAD;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Resuming from BREAK masks the compare for one enabled cycle.
    always_comb begin
        skip_d = skip_q;
        if ((state_q == ST_BREAK) && (state_d == ST_RUN)) skip_d = 1'b1;
        else if (cpu_en)                                  skip_d = 1'b0;
    end

    always_comb begin
        cycles_d = cycles_q;
        if (ld_exit)                           cycles_d = '0;
        else if (cpu_en && cycles_q != CYC_MAX) cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cycles_q <= '0;
            skip_q   <= 1'b0;
            crst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cycles_q <= cycles_d;
            skip_q   <= skip_d;
            crst_q   <= !ld_exit;
        end
    end

    assign CPU_EN    = cpu_en;
    assign CPU_RST_N = crst_q && RST;
    assign STATE     = state_q;
    assign CYCLES    = cycles_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Randomized bench for mips_run_ctrl against a behavioural model,
// including a simple core whose PC loops over 0..28.
module tb_mips_run_ctrl;

    localparam int AW    = 6;
    localparam int WD    = 10;
    localparam int DEPTH = 1 << AW;

    localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2;
    localparam int S_STEP = 3, S_BREAK = 4, S_TIMEOUT = 5;

`ifdef RUN_CTRL_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          BTN_RUN = 1'b0, BTN_STEP = 1'b0, BTN_LOAD = 1'b0;
    logic          LD_VALID = 1'b0;
    logic [31:0]   LD_DATA = '0;
    logic          LD_READY, IM_WE, CPU_EN, CPU_RST_N;
    logic [AW-1:0] IM_ADDR;
    logic [31:0]   IM_WDATA, CYCLES;
    logic [31:0]   PC = '0, BRK_PC = '0;
    logic          BRK_EN = 1'b0;
    logic [2:0]    STATE;

    always #5 CLK = ~CLK;

    mips_run_ctrl #(
        .ADDR_W      (AW),
        .WDOG_CYCLES (WD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .BTN_RUN   (BTN_RUN),
        .BTN_STEP  (BTN_STEP),
        .BTN_LOAD  (BTN_LOAD),
        .LD_VALID  (LD_VALID),
        .LD_DATA   (LD_DATA),
        .LD_READY  (LD_READY),
        .IM_WE     (IM_WE),
        .IM_ADDR   (IM_ADDR),
        .IM_WDATA  (IM_WDATA),
        .CPU_EN    (CPU_EN),
        .CPU_RST_N (CPU_RST_N),
        .PC        (PC),
        .BRK_EN    (BRK_EN),
        .BRK_PC    (BRK_PC),
        .STATE     (STATE),
        .CYCLES    (CYCLES)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;

    int          m_st;
    bit          m_crst;
    logic [31:0] m_cyc;
    int          m_next;
    bit          m_skip;
    int          m_wcnt;
    logic [31:0] m_pc;
    wr_t         pend[$];

    task automatic model_reset();
        m_st   = S_IDLE;
        m_crst = 1'b0;
        m_cyc  = '0;
        m_next = 0;
        m_skip = 1'b0;
        m_wcnt = 0;
        m_pc   = '0;
        pend.delete();
    endtask

    task automatic cycle(input bit rst, input bit bl, input bit br,
                         input bit bs, input bit v, input logic [31:0] d);
        bit  rdy, hit, en, lastw, exit_ld;
        int  nx;
        wr_t w;
        RST = rst; BTN_LOAD = bl; BTN_RUN = br; BTN_STEP = bs;
        LD_VALID = v; LD_DATA = d; PC = m_pc;
        #3;
        hit = BRK_EN && (PC == BRK_PC) && !m_skip;
        en  = (m_st == S_STEP) || (m_st == S_RUN && !hit);
        rdy = (m_st == S_LOAD) && !bl && (m_next < DEPTH);
        chk("state", 32'(STATE), 32'(m_st));
        chk("ld_ready", 32'(LD_READY), 32'(rdy));
        chk("cpu_en", 32'(CPU_EN), 32'(en));
        chk("cpu_rst_n", 32'(CPU_RST_N), 32'(m_crst && rst));
        chk("cycles", CYCLES, m_cyc);
        chk("im_we", 32'(IM_WE), 32'(pend.size() != 0));
        if (pend.size() != 0) begin
            chk("im_addr", 32'(IM_ADDR), 32'(pend[0].a));
            chk("im_wdata", IM_WDATA, pend[0].d);
        end
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else begin
            lastw = 1'b0;
            if (pend.size() != 0) begin
                w     = pend.pop_front();
                lastw = (w.a == DEPTH - 1);
            end
            if (rdy && v) begin
                pend.push_back('{a: m_next, d: d});
                m_next++;
            end
            nx = m_st;
            case (m_st)
                S_IDLE, S_BREAK: begin
                    if (bl)      nx = S_LOAD;
                    else if (br) nx = S_RUN;
                    else if (bs) nx = S_STEP;
                end
                S_LOAD:    if (bl || lastw) nx = S_IDLE;
                S_RUN: begin
                    if (bl)       nx = S_LOAD;
                    else if (br)  nx = S_IDLE;
                    else if (hit) nx = S_BREAK;
                    else if (WDOG_ON && en && m_wcnt + 1 == WD)
                        nx = S_TIMEOUT;
                end
                S_STEP:    nx = S_IDLE;
                S_TIMEOUT: if (bl) nx = S_LOAD;
                default:   nx = S_IDLE;
            endcase
            exit_ld = (m_st == S_LOAD) && (nx == S_IDLE);
            if (exit_ld) m_cyc = '0;
            else if (en && m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 32'd1;
            if (!m_crst) m_pc = '0;
            else if (en) m_pc = (m_pc + 32'd4) & 32'h1F;
            m_crst = !exit_ld;
            if (m_st == S_BREAK && nx == S_RUN) m_skip = 1'b1;
            else if (en)                        m_skip = 1'b0;
            if (nx == S_RUN && m_st != S_RUN)  m_wcnt = 0;
            else if (m_st == S_RUN && en)      m_wcnt++;
            if (nx == S_LOAD && m_st != S_LOAD) m_next = 0;
            m_st = nx;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, '0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_ld_ready", 32'(LD_READY), 32'd0);
        chk("rst_im_we", 32'(IM_WE), 32'd0);
        chk("rst_im_addr", 32'(IM_ADDR), 32'd0);
        chk("rst_im_wdata", IM_WDATA, 32'd0);
        chk("rst_cpu_en", 32'(CPU_EN), 32'd0);
        chk("rst_cpu_rst_n", 32'(CPU_RST_N), 32'd0);
        chk("rst_cycles", CYCLES, 32'd0);

        cycle(1, 1, 0, 0, 0, '0);
        cycle(1, 0, 0, 0, 1, 32'h2008_0005);
        cycle(1, 0, 0, 0, 1, 32'h2108_0001);
        cycle(1, 0, 0, 0, 1, 32'h0800_0001);
        cycle(1, 1, 0, 0, 0, '0);
        chk("load3_state", 32'(STATE), 32'd0);
        chk("load3_cycles", CYCLES, 32'd0);
        idle(1);

        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 0, '0);
            idle(4);
        end
        chk("step3_cycles", CYCLES, 32'd3);

        cycle(1, 1, 0, 0, 0, '0);
        cycle(1, 1, 0, 0, 0, '0);
        idle(1);
        BRK_EN = 1'b1;
        BRK_PC = 32'h8;
        cycle(1, 0, 1, 0, 0, '0);
        idle(5);
        chk("brk_state", 32'(STATE), 32'd4);
        chk("brk_cycles", CYCLES, 32'd2);

        cycle(1, 0, 1, 0, 0, '0);
        idle(12);
        chk("rebrk_state", 32'(STATE), 32'd4);
        chk("rebrk_cycles", CYCLES, 32'd10);

        cycle(1, 0, 0, 1, 0, '0);
        idle(1);
        chk("brkstep_state", 32'(STATE), 32'd0);
        chk("brkstep_cycles", CYCLES, 32'd11);

        cycle(1, 1, 1, 0, 0, '0);
        idle(1);
        chk("prio_state", 32'(STATE), 32'd1);

        for (int i = 0; i < DEPTH + 6; i++) cycle(1, 0, 0, 0, 1, $urandom);
        chk("full_state", 32'(STATE), 32'd0);
        chk("full_cycles", CYCLES, 32'd0);

        BRK_EN = 1'b0;
        cycle(1, 0, 1, 0, 0, '0);
        idle(20);
        cycle(0, 0, 0, 0, 0, '0);
        chk("midrst_state", 32'(STATE), 32'd0);
        chk("midrst_cycles", CYCLES, 32'd0);
        chk("midrst_cpu_en", 32'(CPU_EN), 32'd0);
        chk("midrst_cpu_rst_n", 32'(CPU_RST_N), 32'd0);
        idle(2);

`ifdef RUN_CTRL_WDOG_EN
        cycle(1, 0, 1, 0, 0, '0);
        idle(15);
        chk("wdog_state", 32'(STATE), 32'd5);
        chk("wdog_cycles", CYCLES, 32'd10);
        cycle(1, 0, 1, 0, 0, '0);
        cycle(1, 0, 0, 1, 0, '0);
        chk("wdog_hold", 32'(STATE), 32'd5);
        cycle(1, 1, 0, 0, 0, '0);
        chk("wdog_load", 32'(STATE), 32'd1);
        cycle(1, 1, 0, 0, 0, '0);
`endif

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                BRK_EN = 1'($urandom_range(0, 1));
                BRK_PC = 32'(4 * $urandom_range(0, 7));
            end
            cycle($urandom_range(0, 299) != 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Execution controller that sits between the debounced button outputs and the single-cycle MIPS core on the board top level.
- Sequences instruction-memory loading.
- Gates the core with a clock enable for run, single-step and pause.
- Stops at a hardware breakpoint and counts executed cycles for display on the 7-segment digits.
- The core, instruction memory and display decoders are unchanged; this block only drives their enables and write port.

Parameters:
ADDR_W, 6, instruction-memory word-address width; load depth is 2**ADDR_W words.
WDOG_CYCLES, 1000000, run-cycle limit used only when RUN_CTRL_WDOG_EN is defined.

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-low
BTN_RUN  in  1  one-cycle pulse from the debouncer: run/pause toggle
BTN_STEP  in  1  one-cycle pulse: execute one instruction
BTN_LOAD  in  1  one-cycle pulse: enter or leave load mode
LD_VALID  in  1  load word valid
LD_DATA  in  32  instruction word to load
LD_READY  out  1  load word accepted when VALID && READY
IM_WE  out  1  instruction-memory write enable
IM_ADDR  out  ADDR_W  instruction-memory write address
IM_WDATA  out  32  instruction-memory write data
CPU_EN  out  1  core clock enable; the core advances one instruction per cycle with CPU_EN=1
CPU_RST_N  out  1  core reset, active-low, one-cycle pulse
PC  in  32  current core PC (byte address)
BRK_EN  in  1  breakpoint enable
BRK_PC  in  32  breakpoint PC
STATE  out  3  current FSM state encoding
CYCLES  out  32  count of cycles with CPU_EN=1

Behaviour:
- Reset (RST=0 at a rising edge): state IDLE.
  - Outputs: LD_READY=0, IM_WE=0, IM_ADDR=0, IM_WDATA=0, CPU_EN=0, CPU_RST_N=0 (core held in reset while RST=0), CYCLES=0.
  - Reset mid-load or mid-run aborts immediately; a partially written memory is not cleared.
- State encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, BREAK=4, TIMEOUT=5 (TIMEOUT only with the macro).
- Button priority on simultaneous pulses: LOAD > RUN > STEP. Pulses not valid in the current state are dropped.
- IDLE: CPU_EN=0.
  - BTN_LOAD -> LOAD, with the word address cleared to 0.
  - BTN_RUN -> RUN.
  - BTN_STEP -> STEP.
- LOAD: LD_READY=1.
  - On handshake: IM_WE=1 for one cycle on the next cycle, with IM_ADDR = current word address and IM_WDATA = registered LD_DATA; the address then increments. One write per cycle max, so back-to-back VALID gives back-to-back writes.
  - After the write to address 2**ADDR_W-1, or on BTN_LOAD: -> IDLE, with CPU_RST_N=0 for exactly one cycle and CYCLES cleared.
  - LD_READY drops in the cycle the FSM leaves LOAD. No address wrap; a word offered on exit is not accepted.
- STEP: CPU_EN=1 for exactly one cycle, then -> IDLE. A step from BREAK uses the same path, then returns to IDLE.
- RUN:
  - CPU_EN=1 each cycle unless a breakpoint hits.
  - Breakpoint hit = BRK_EN && PC==BRK_PC && !skip. On a hit, CPU_EN=0 in the same cycle (combinational) and the next state is BREAK, so the instruction at BRK_PC is not executed.
  - BTN_RUN -> IDLE (pause); CPU_EN is 0 in the cycle after the pulse.
  - BTN_LOAD -> LOAD; CPU_EN is 0 in the cycle after the pulse.
- BREAK: CPU_EN=0.
  - BTN_RUN -> RUN with skip=1. skip clears after the first enabled cycle, so execution leaves BRK_PC.
  - BTN_STEP -> STEP.
  - BTN_LOAD -> LOAD.
- CYCLES increments on every cycle with CPU_EN=1 and saturates at 32'hFFFFFFFF.
- STATE is registered and reflects the FSM state.

Optional Feature:
Macro RUN_CTRL_WDOG_EN.
- Defined: a run counter clears on entry to RUN and counts enabled RUN cycles. When it reaches WDOG_CYCLES, the FSM goes -> TIMEOUT with CPU_EN=0. TIMEOUT exits only on BTN_LOAD (-> LOAD) or reset; BTN_RUN and BTN_STEP are ignored.
- Undefined: no counter, no TIMEOUT state, and encoding 5 is never produced.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state typedef and encodings;
  - the CYCLES saturation constant;
  - the default ADDR_W.
- One sub-module, mips_imem_loader, holds the LOAD-state handshake, address counter and registered write port. Its done pulse is consumed by the FSM.
- The FSM, breakpoint compare and cycle counter stay in the top block.

Test Plan:
- Reset then load 3 words (0x20080005, 0x21080001, 0x08000001) and press BTN_LOAD -> IM_WE pulses at addresses 0, 1, 2 with matching data; one-cycle CPU_RST_N low on exit; STATE=0; CYCLES=0.
- From IDLE, BTN_STEP 3 times, 5 cycles apart -> exactly 3 single-cycle CPU_EN pulses; CYCLES=3.
- BRK_EN=1, BRK_PC=0x8, BTN_RUN with core PC advancing 0, 4, 8 -> CPU_EN high for 2 cycles, low when PC=0x8; STATE=4; CYCLES=2.
- In BREAK, BTN_RUN -> CPU_EN=1 in the first RUN cycle despite PC==BRK_PC; the next match re-breaks.
- BTN_RUN and BTN_LOAD pulsed in the same IDLE cycle -> LOAD entered; LD_READY=1; CPU_EN stays 0.
- RST=0 for one cycle during RUN with CYCLES=100 -> next cycle STATE=0, CPU_EN=0, CYCLES=0, CPU_RST_N=0 while RST=0.
- With RUN_CTRL_WDOG_EN and WDOG_CYCLES=10, BTN_RUN -> exactly 10 enabled cycles then STATE=5; BTN_RUN ignored; BTN_LOAD -> STATE=1.
